yutorina_bus_slave_mux_tmo: RTL and testbench
=============================================

Name: yutorina_bus_slave_mux_tmo

Overview:
- Parametrised successor to the 8-slave combinational read/ready mux.
- Handles NUM_SLAVES slaves through flattened vectors and registers the response toward the master.
- A per-transaction watchdog terminates the access with an error if the selected slave never asserts ready.
- Sits between the bus address decoder / slave array and the bus master interface of the CPU or bus arbiter.

Parameters:
- NUM_SLAVES, 8: number of slave ports, 1..16.
- DATA_W, 32: read data width (matches word data bus).
- TIMEOUT, 255: cycles waited for slave ready before error termination; must be ≥1.
- CNT_W, 8: watchdog counter width; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m_as_  in  1  master address strobe, active low; marks transaction start
- s_cs_  in  NUM_SLAVES  slave chip selects from decoder, active low, bit i = slave i
- s_r_data  in  NUM_SLAVES*DATA_W  slave read data, slave i at bits [i*DATA_W +: DATA_W]
- s_rdy_  in  NUM_SLAVES  slave ready, active low
- err_clr  in  1  clears sticky status bits
- m_r_data  out  DATA_W  registered read data to master
- m_rdy_  out  1  registered ready to master, active low, one-cycle pulse
- m_err  out  1  high with m_rdy_ when the transaction timed out or had no slave selected
- st_tmo  out  1  sticky: a timeout occurred
- st_multi  out  1  sticky: more than one cs_ was low at transaction start

Behaviour:
- Reset values (asynchronous, immediate): state IDLE; m_r_data = 0; m_rdy_ = 1 (disabled); m_err = 0; st_tmo = 0; st_multi = 0; counter = 0; selected index = 0.
- Reset asserted mid-transaction: the access is abandoned and no m_rdy_ is issued.
- State IDLE:
  - Start condition: m_as_ = 0.
  - Latch sel = lowest index i with s_cs_[i] = 0 (lowest index has priority).
  - If more than one cs_ is low at start, set st_multi.
  - If no cs_ is low at start, go to RESP with data 0 and m_err = 1 (unmapped access).
  - Otherwise clear the counter and go to WAIT.
- State WAIT, per cycle, in priority order:
  - If s_cs_[sel] = 1, the master aborted: go to IDLE with no response.
  - Else if s_rdy_[sel] = 0: capture s_r_data slice sel into m_r_data, m_err = 0, go to RESP.
  - Else if counter == TIMEOUT - 1: m_r_data = 0, m_err = 1, set st_tmo, go to RESP.
  - Else increment the counter.
- State RESP:
  - m_rdy_ = 0 for exactly one cycle; m_r_data / m_err are valid in the same cycle.
  - Next state IDLE; m_rdy_ returns to 1 and m_err to 0.
  - m_r_data holds its value until the next capture.
- Latency:
  - Slave ready in cycle t gives m_rdy_ low in cycle t+1.
  - Minimum transaction: m_as_ at t0, slave ready at t0+1, m_rdy_ at t0+2.
- Only s_cs_/s_rdy_ of the latched sel are observed after start; changes on other slaves are ignored.
- m_as_ while not in IDLE is ignored; the master must not start a new access before m_rdy_.
- Timeout boundary:
  - A ready arriving in the same cycle the counter reaches TIMEOUT-1 wins (normal response, no error).
  - With TIMEOUT = 1, the ready must arrive in the first WAIT cycle.
- Sticky bits:
  - Cleared by err_clr.
  - If err_clr and a new set event occur in the same cycle, set wins.
- No combinational path from any s_* input to any output.

Decomposition:
- Shared header bus.h gains:
  - BUS_SLAVE_MAX (16)
  - state encodings BUS_MUX_IDLE / BUS_MUX_WAIT / BUS_MUX_RESP (2 bits)
  - default TIMEOUT value
- Reuse ENABLE_/DISABLE_/ZERO from stddef.h.
- Natural sub-module: yutorina_bus_prio_enc. A parametrised lowest-index priority encoder over active-low cs_ vector, outputting index, any-valid, and multiple-valid flags.

Test Plan:
- Normal read: m_as_=0 with s_cs_=8'b1111_1011, slave 2 s_rdy_=0 two cycles later with data 32'hDEAD_BEEF → m_rdy_=0 one cycle after slave ready, m_r_data=32'hDEAD_BEEF, m_err=0, then m_rdy_=1.
- Priority/multi: s_cs_=8'b1110_0111 (slaves 3,4) with data 32'h3333_3333 / 32'h4444_4444, both ready → m_r_data=32'h3333_3333, st_multi=1; err_clr pulse → st_multi=0.
- Timeout: TIMEOUT=4, slave 5 selected, never ready → m_rdy_=0 with m_err=1, m_r_data=0 exactly 5 cycles after m_as_ (1 start + 4 WAIT), st_tmo=1.
- Ready at boundary: TIMEOUT=4, slave ready in 4th WAIT cycle with 32'h0000_00A5 → m_err=0, m_r_data=32'h0000_00A5, st_tmo stays 0.
- Unmapped/abort: m_as_=0 with s_cs_ all 1 → m_rdy_=0, m_err=1 next cycle. Separately, deasserting the selected cs_ in WAIT → no m_rdy_, FSM back to IDLE.
- Reset mid-WAIT: assert reset during WAIT → outputs immediately at reset values, no m_rdy_ after release; a following normal read completes correctly.

Source files
------------

// File: rtl/yutorina_bus_slave_mux_tmo_pkg.sv
// Shared bus definitions for the slave response mux: slave limits, FSM encodings, active-low levels.
// Pure declarations; no logic, latency or backpressure of its own.
package yutorina_bus_slave_mux_tmo_pkg;

    localparam int BUS_SLAVE_MAX   = 16;
    localparam int BUS_TIMEOUT_DEF = 255;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic ZERO     = 1'b0;

    typedef enum logic [1:0] {
        BUS_MUX_IDLE = 2'd0,
        BUS_MUX_WAIT = 2'd1,
        BUS_MUX_RESP = 2'd2
    } bus_mux_state_e;

endpackage

// File: rtl/yutorina_bus_prio_enc.sv
// Lowest-index priority encoder over an active-low chip-select vector, with any/multiple flags.
// Purely combinational; no backpressure.
module yutorina_bus_prio_enc
    import yutorina_bus_slave_mux_tmo_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     cs_,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             multi
);

    always_comb begin
        idx   = '0;
        any   = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (cs_[i] == ENABLE_) begin
                if (any) begin
                    multi = 1'b1;
                end else begin
                    any = 1'b1;
                    idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/yutorina_bus_slave_mux_tmo.sv
// Registered read/ready mux from NUM_SLAVES slaves to the master, with a per-access ready watchdog.
// Slave ready in cycle t gives m_rdy_ in t+1; a silent slave is cut off after TIMEOUT wait cycles.
module yutorina_bus_slave_mux_tmo
    import yutorina_bus_slave_mux_tmo_pkg::*;
#(
    parameter int NUM_SLAVES = 8,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = BUS_TIMEOUT_DEF,
    parameter int CNT_W      = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         m_as_,
    input  logic [NUM_SLAVES-1:0]        s_cs_,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_r_data,
    input  logic [NUM_SLAVES-1:0]        s_rdy_,
    input  logic                         err_clr,
    output logic [DATA_W-1:0]            m_r_data,
    output logic                         m_rdy_,
    output logic                         m_err,
    output logic                         st_tmo,
    output logic                         st_multi
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    bus_mux_state_e    state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [SEL_W-1:0]  sel, sel_nxt;
    logic [DATA_W-1:0] dat_nxt;
    logic              rdy_nxt, err_nxt;
    logic              tmo_set, multi_set;

    logic [SEL_W-1:0]  enc_idx;
    logic              enc_any, enc_multi;
    logic [DATA_W-1:0] slv_dat [NUM_SLAVES];

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slice
        assign slv_dat[g] = s_r_data[g*DATA_W +: DATA_W];
    end

    yutorina_bus_prio_enc #(
        .N     (NUM_SLAVES),
        .IDX_W (SEL_W)
    ) u_prio_enc (
        .cs_   (s_cs_),
        .idx   (enc_idx),
        .any   (enc_any),
        .multi (enc_multi)
    );

    // Every output is a flop; s_* only ever feeds next-state logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel;
        dat_nxt   = m_r_data;
        rdy_nxt   = DISABLE_;
        err_nxt   = ZERO;
        tmo_set   = 1'b0;
        multi_set = 1'b0;
        case (state)
            BUS_MUX_IDLE: begin
                if (m_as_ == ENABLE_) begin
                    sel_nxt   = enc_idx;
                    multi_set = enc_multi;
                    if (!enc_any) begin
                        dat_nxt   = '0;
                        rdy_nxt   = ENABLE_;
                        err_nxt   = 1'b1;
                        state_nxt = BUS_MUX_RESP;
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = BUS_MUX_WAIT;
                    end
                end
            end
            BUS_MUX_WAIT: begin
                if (s_cs_[sel] == DISABLE_) begin
                    state_nxt = BUS_MUX_IDLE;
                end else if (s_rdy_[sel] == ENABLE_) begin
                    dat_nxt   = slv_dat[sel];
                    rdy_nxt   = ENABLE_;
                    state_nxt = BUS_MUX_RESP;
                end else if (cnt == TMO_LAST) begin
                    dat_nxt   = '0;
                    rdy_nxt   = ENABLE_;
                    err_nxt   = 1'b1;
                    tmo_set   = 1'b1;
                    state_nxt = BUS_MUX_RESP;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            BUS_MUX_RESP: state_nxt = BUS_MUX_IDLE;
            default:      state_nxt = BUS_MUX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= BUS_MUX_IDLE;
            cnt      <= '0;
            sel      <= '0;
            m_r_data <= '0;
            m_rdy_   <= DISABLE_;
            m_err    <= ZERO;
            st_tmo   <= ZERO;
            st_multi <= ZERO;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sel      <= sel_nxt;
            m_r_data <= dat_nxt;
            m_rdy_   <= rdy_nxt;
            m_err    <= err_nxt;
            // A new event in the same cycle as err_clr must not be lost.
            st_tmo   <= tmo_set   | (st_tmo   & ~err_clr);
            st_multi <= multi_set | (st_multi & ~err_clr);
        end
    end

endmodule

// File: tb/tb_yutorina_bus_slave_mux_tmo.sv
// Directed bench for the slave response mux with a short watchdog (TIMEOUT = 4).
module tb_yutorina_bus_slave_mux_tmo;

    localparam int NS = 8;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              m_as_;
    logic [NS-1:0]     s_cs_;
    logic [NS*DW-1:0]  s_r_data;
    logic [NS-1:0]     s_rdy_;
    logic              err_clr;
    logic [DW-1:0]     m_r_data;
    logic              m_rdy_;
    logic              m_err;
    logic              st_tmo;
    logic              st_multi;

    int checks = 0;
    int errors = 0;

    yutorina_bus_slave_mux_tmo #(
        .NUM_SLAVES (NS),
        .DATA_W     (DW),
        .TIMEOUT    (4),
        .CNT_W      (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m_as_    (m_as_),
        .s_cs_    (s_cs_),
        .s_r_data (s_r_data),
        .s_rdy_   (s_rdy_),
        .err_clr  (err_clr),
        .m_r_data (m_r_data),
        .m_rdy_   (m_rdy_),
        .m_err    (m_err),
        .st_tmo   (st_tmo),
        .st_multi (st_multi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge: outputs of the new cycle are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        m_as_   = 1'b1;
        s_cs_   = '1;
        s_rdy_  = '1;
        err_clr = 1'b0;
    endtask

    task automatic set_dat(input int i, input logic [31:0] v);
        s_r_data[i*DW +: DW] = v;
    endtask

    // Watch n cycles and count any m_rdy_ pulse.
    task automatic no_rdy(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (m_rdy_ == 1'b0) seen++;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        idle_bus();
        s_r_data = '0;
        reset    = 1'b1;
        #12;
        chk("rst_rdy",   m_rdy_,   1);
        chk("rst_err",   m_err,    0);
        chk("rst_dat",   m_r_data, 0);
        chk("rst_tmo",   st_tmo,   0);
        chk("rst_multi", st_multi, 0);
        reset = 1'b0;
        tick();

        // Normal read, slave 2 ready two cycles after the strobe
        m_as_ = 1'b0; s_cs_ = 8'b1111_1011;
        set_dat(2, 32'hDEAD_BEEF);
        set_dat(3, 32'h0BAD_0BAD);
        tick();
        m_as_ = 1'b1;
        s_rdy_ = 8'b1111_0111;
        chk("nrm_wait_rdy", m_rdy_, 1);
        tick();
        s_rdy_ = 8'b1111_1011;
        tick();
        chk("nrm_rdy", m_rdy_,   0);
        chk("nrm_dat", m_r_data, 32'hDEAD_BEEF);
        chk("nrm_err", m_err,    0);
        idle_bus();
        tick();
        chk("nrm_rdy_off", m_rdy_,   1);
        chk("nrm_hold",    m_r_data, 32'hDEAD_BEEF);

        // Two slaves selected: lowest index wins, multi flag set
        m_as_ = 1'b0; s_cs_ = 8'b1110_0111; s_rdy_ = 8'b1110_0111;
        set_dat(3, 32'h3333_3333);
        set_dat(4, 32'h4444_4444);
        tick();
        m_as_ = 1'b1;
        chk("mul_flag", st_multi, 1);
        tick();
        chk("mul_rdy", m_rdy_,   0);
        chk("mul_dat", m_r_data, 32'h3333_3333);
        idle_bus();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("mul_clr", st_multi, 0);

        // Clear coinciding with a new multi-select start: set wins
        m_as_ = 1'b0; s_cs_ = 8'b1111_1100; s_rdy_ = 8'b1111_1110; err_clr = 1'b1;
        set_dat(0, 32'h0000_0C0C);
        tick();
        m_as_ = 1'b1; err_clr = 1'b0;
        chk("mul_setwins", st_multi, 1);
        tick();
        chk("mul0_dat", m_r_data, 32'h0000_0C0C);
        idle_bus();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Timeout on slave 5: response exactly 5 cycles after the strobe
        m_as_ = 1'b0; s_cs_ = 8'b1101_1111;
        set_dat(5, 32'h5555_5555);
        for (int c = 1; c <= 4; c++) begin
            tick();
            m_as_ = 1'b1;
            chk($sformatf("tmo_wait%0d", c), m_rdy_, 1);
        end
        tick();
        chk("tmo_rdy", m_rdy_,   0);
        chk("tmo_err", m_err,    1);
        chk("tmo_dat", m_r_data, 0);
        chk("tmo_st",  st_tmo,   1);
        idle_bus();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("tmo_clr", st_tmo, 0);
        chk("tmo_err_off", m_err, 0);

        // Ready in the 4th wait cycle still beats the watchdog
        m_as_ = 1'b0; s_cs_ = 8'b1011_1111;
        set_dat(6, 32'h0000_00A5);
        tick();
        m_as_ = 1'b1;
        tick();
        tick();
        tick();
        s_rdy_ = 8'b1011_1111;
        tick();
        chk("bnd_rdy", m_rdy_,   0);
        chk("bnd_err", m_err,    0);
        chk("bnd_dat", m_r_data, 32'h0000_00A5);
        chk("bnd_tmo", st_tmo,   0);
        idle_bus();
        tick();

        // Unmapped access
        m_as_ = 1'b0;
        tick();
        m_as_ = 1'b1;
        chk("unm_rdy", m_rdy_,   0);
        chk("unm_err", m_err,    1);
        chk("unm_dat", m_r_data, 0);
        tick();
        chk("unm_rdy_off", m_rdy_, 1);

        // Master drops the selected cs_ during wait: no response
        m_as_ = 1'b0; s_cs_ = 8'b1111_1101;
        tick();
        m_as_ = 1'b1;
        s_cs_ = 8'b1111_1111;
        no_rdy("abort_none", 6);

        // Reset in the middle of a wait
        m_as_ = 1'b0; s_cs_ = 8'b1111_1101;
        set_dat(1, 32'h1111_1111);
        s_rdy_ = 8'b1111_1101;
        tick();
        m_as_ = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_rdy", m_rdy_,   1);
        chk("mid_rst_dat", m_r_data, 0);
        tick();
        reset = 1'b0;
        s_rdy_ = '1;
        no_rdy("mid_rst_none", 6);
        idle_bus();
        tick();

        // Normal read after the reset, slave 0 ready on the first wait cycle
        m_as_ = 1'b0; s_cs_ = 8'b1111_1110; s_rdy_ = 8'b1111_1110;
        set_dat(0, 32'h1234_5678);
        tick();
        m_as_ = 1'b1;
        tick();
        chk("post_rdy", m_rdy_,   0);
        chk("post_dat", m_r_data, 32'h1234_5678);
        chk("post_err", m_err,    0);
        idle_bus();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
